// File: rtl/dii_event_packetizer_pkg.sv
// Shared DII definitions for the event packetizer slice.
// - dii_flit: one 16-bit flit plus its valid and last-of-packet flags.
// - DII_TYPE_*: encodings carried in the TYPE header flit.
// - DII_HDR_FLITS: number of header flits (DEST, SRC, TYPE) ahead of the payload.
package dii_event_packetizer_pkg;

  localparam int DII_FLIT_W = 16;

  typedef struct packed {
    logic                  valid;
    logic                  last;
    logic [DII_FLIT_W-1:0] data;
  } dii_flit;

  localparam logic [1:0] DII_TYPE_REG   = 2'b00;
  localparam logic [1:0] DII_TYPE_PLAIN = 2'b01;
  localparam logic [1:0] DII_TYPE_EVENT = 2'b10;

  localparam int DII_HDR_FLITS = 3;

endpackage

// File: rtl/dii_event_packetizer_if.sv
// DII flit link between a flit source and a flit sink.
// - flit  : {valid, last, data}, driven by the source (master).
// - ready : driven by the sink (slave).
// Handshake: a flit transfers on a clock edge where flit.valid && ready. Once
// valid is raised, valid/last/data hold unchanged until that transfer; ready
// may change freely and the source never waits on ready before raising valid.
interface dii_event_packetizer_if;
  import dii_event_packetizer_pkg::*;

  dii_flit flit;
  logic    ready;

  modport master (output flit, input ready);
  modport slave  (input flit, output ready);
endinterface

// File: rtl/dii_event_packetizer.sv
// Turns one wide debug event into a DII packet: DEST, SRC, TYPE header
// flits followed by 0..MAX_DATA_NUM_WORDS payload words, one flit per cycle.
// Ports:
// - clk, rst_n        : clock, asynchronous active-low reset.
// - id, dest          : own / destination DII address, sampled at accept.
// - dii_type, type_sub: DII packet type / subtype, sampled at accept.
// - event_available   : producer has an event ready.
// - event_data        : payload, word i = bits [16*i+15:16*i].
// - data_num_words    : payload length, clamped to MAX_DATA_NUM_WORDS.
// - event_consumed    : accept strobe; the event is latched in this cycle.
// - flit_out          : DII flit link (master side), driven from registers.
// - state_dbg         : current FSM state encoding.
module dii_event_packetizer
  import dii_event_packetizer_pkg::*;
#(
  parameter  int MAX_DATA_NUM_WORDS = 8,
  localparam int CNT_W = $clog2(MAX_DATA_NUM_WORDS + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [15:0]                     id,
  input  logic [15:0]                     dest,
  input  logic [1:0]                      dii_type,
  input  logic [3:0]                      type_sub,
  input  logic                            event_available,
  input  logic [16*MAX_DATA_NUM_WORDS-1:0] event_data,
  input  logic [CNT_W-1:0]                data_num_words,
  output logic                            event_consumed,
  dii_event_packetizer_if.master          flit_out,
  output logic [2:0]                      state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DEST    = 3'd1,
    S_SRC     = 3'd2,
    S_TYPE    = 3'd3,
    S_PAYLOAD = 3'd4
  } state_t;

  state_t                          state;
  dii_flit                         flit_q;
  logic [CNT_W-1:0]                cnt;
  logic [CNT_W-1:0]                nwords_q;
  logic [15:0]                     id_q;
  logic [15:0]                     dest_q;
  logic [1:0]                      type_q;
  logic [3:0]                      sub_q;
  logic [16*MAX_DATA_NUM_WORDS-1:0] event_q;

  logic                            fire;
  logic [CNT_W-1:0]                nwords_clamped;
  logic [CNT_W-1:0]                cnt_next;
  logic [15:0]                     word_mux;
  logic                            last_next;

  assign flit_out.flit = flit_q;
  assign fire          = flit_q.valid && flit_out.ready;
  assign state_dbg     = state;

  // Held low during reset even though the state register already reads IDLE.
  assign event_consumed = rst_n && (state == S_IDLE) && event_available;

  assign nwords_clamped = (data_num_words > CNT_W'(MAX_DATA_NUM_WORDS))
                          ? CNT_W'(MAX_DATA_NUM_WORDS) : data_num_words;

  // Index of the payload word loaded on the next fire: word 0 when leaving
  // TYPE, otherwise the word after the one currently on the bus.
  always_comb begin
    cnt_next = '0;
    if (state == S_PAYLOAD) cnt_next = cnt + CNT_W'(1);
    word_mux = '0;
    for (int i = 0; i < MAX_DATA_NUM_WORDS; i++) begin
      if (cnt_next == CNT_W'(i)) word_mux = event_q[16*i +: 16];
    end
    last_next = (cnt_next == nwords_q - CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      flit_q   <= '0;
      cnt      <= '0;
      nwords_q <= '0;
      id_q     <= '0;
      dest_q   <= '0;
      type_q   <= '0;
      sub_q    <= '0;
      event_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (event_available) begin
            id_q        <= id;
            dest_q      <= dest;
            type_q      <= dii_type;
            sub_q       <= type_sub;
            event_q     <= event_data;
            nwords_q    <= nwords_clamped;
            flit_q.valid <= 1'b1;
            flit_q.last  <= 1'b0;
            flit_q.data  <= dest;
            state       <= S_DEST;
          end
        end
        S_DEST: begin
          if (fire) begin
            flit_q.data <= id_q;
            state       <= S_SRC;
          end
        end
        S_SRC: begin
          if (fire) begin
            flit_q.data <= {type_q, sub_q, 10'b0};
            flit_q.last <= (nwords_q == '0);
            state       <= S_TYPE;
          end
        end
        S_TYPE: begin
          if (fire) begin
            if (nwords_q == '0) begin
              flit_q <= '0;
              state  <= S_IDLE;
            end else begin
              cnt         <= '0;
              flit_q.data <= word_mux;
              flit_q.last <= last_next;
              state       <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (fire) begin
            if (flit_q.last) begin
              flit_q <= '0;
              state  <= S_IDLE;
            end else begin
              cnt         <= cnt_next;
              flit_q.data <= word_mux;
              flit_q.last <= last_next;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dii_event_packetizer.sv
module tb_dii_event_packetizer;
  import dii_event_packetizer_pkg::*;

  localparam int MAX   = 8;
  localparam int CNT_W = $clog2(MAX + 1);

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  logic [15:0]        id;
  logic [15:0]        dest;
  logic [1:0]         dii_type;
  logic [3:0]         type_sub;
  logic               event_available;
  logic [16*MAX-1:0]  event_data;
  logic [CNT_W-1:0]   data_num_words;
  logic               event_consumed;
  logic [2:0]         state_dbg;
  logic               ready;

  dii_event_packetizer_if link();
  assign link.ready = ready;

  dii_event_packetizer #(.MAX_DATA_NUM_WORDS(MAX)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id              (id),
    .dest            (dest),
    .dii_type        (dii_type),
    .type_sub        (type_sub),
    .event_available (event_available),
    .event_data      (event_data),
    .data_num_words  (data_num_words),
    .event_consumed  (event_consumed),
    .flit_out        (link.master),
    .state_dbg       (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fires = 0;
  int consumed = 0;
  int acc_cyc = 0;
  logic [16:0] exp_q[$];   // {last, data}
  int fire_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- ready generator ----------------
  bit ready_mode = 0;
  int pidx = 0;
  logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode) begin
        ready = pat[pidx];
        pidx  = (pidx + 1) % 6;
      end else begin
        ready = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic    stall_prev = 1'b0;
  dii_flit prev_flit;
  logic [16:0] got;
  logic [16:0] want;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check("stall_valid", 32'(link.flit.valid), 32'd1);
        check("stall_flit", 32'({link.flit.last, link.flit.data}),
              32'({prev_flit.last, prev_flit.data}));
      end
      if (link.flit.valid && ready) begin
        fires++;
        fire_cyc.push_back(cyc);
        got = {link.flit.last, link.flit.data};
        if (exp_q.size() == 0) begin
          check("unexpected_flit", 32'(got), 32'h1ffff);
        end else begin
          want = exp_q.pop_front();
          check("flit", 32'(got), 32'(want));
        end
      end
      stall_prev = link.flit.valid && !ready;
      prev_flit  = link.flit;
      if (event_consumed) consumed++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_pkt(input logic [15:0] d, input logic [15:0] s, input logic [1:0] t,
                          input logic [3:0] st, input int n, input logic [16*MAX-1:0] data);
    int m;
    m = (n > MAX) ? MAX : n;
    exp_q.push_back({1'b0, d});
    exp_q.push_back({1'b0, s});
    exp_q.push_back({(m == 0), t, st, 10'b0});
    for (int i = 0; i < m; i++) exp_q.push_back({(i == m - 1), data[16*i +: 16]});
  endtask

  task automatic send_event(input logic [15:0] d, input logic [15:0] s, input logic [1:0] t,
                            input logic [3:0] st, input int n, input logic [16*MAX-1:0] data,
                            input bit use_model);
    bit ok;
    dest = d; id = s; dii_type = t; type_sub = st;
    data_num_words = CNT_W'(n); event_data = data;
    event_available = 1'b1;
    ok = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (event_consumed) begin
        ok = 1;
        acc_cyc = cyc;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    else if (use_model) push_pkt(d, s, t, st, n, data);
    @(posedge clk);
    #1 event_available = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(posedge clk);
      if (exp_q.size() == 0) ok = 1;
    end
    if (!ok) begin
      check(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [16*MAX-1:0] vec;
  int c0;
  int base;
  initial begin
    rst_n = 1'b0;
    event_available = 1'b1;
    id = 16'h1111; dest = 16'h2222; dii_type = 2'b11; type_sub = 4'hF;
    event_data = '1; data_num_words = CNT_W'(3);
    #12;
    check("rst_valid", 32'(link.flit.valid), 32'd0);
    check("rst_last", 32'(link.flit.last), 32'd0);
    check("rst_data", 32'(link.flit.data), 32'd0);
    check("rst_consumed", 32'(event_consumed), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    event_available = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic 2-word packet, ready high, hand-computed flits
    fire_cyc.delete();
    c0 = consumed;
    exp_q.push_back({1'b0, 16'h0001});
    exp_q.push_back({1'b0, 16'h0005});
    exp_q.push_back({1'b0, 16'h8C00});
    exp_q.push_back({1'b0, 16'hCAFE});
    exp_q.push_back({1'b1, 16'hBEEF});
    vec = '0; vec[31:0] = {16'hBEEF, 16'hCAFE};
    send_event(16'h0001, 16'h0005, DII_TYPE_EVENT, 4'h3, 2, vec, 0);
    wait_drain("t1_drain");
    check("t1_nflits", 32'(fire_cyc.size()), 32'd5);
    if (fire_cyc.size() == 5) begin
      check("t1_latency", 32'(fire_cyc[0]), 32'(acc_cyc + 1));
      check("t1_consecutive", 32'(fire_cyc[4] - fire_cyc[0]), 32'd4);
    end
    check("t1_consumed", 32'(consumed - c0), 32'd1);

    // 2: zero-word packet with a second event queued behind it
    fire_cyc.delete();
    c0 = consumed;
    exp_q.push_back({1'b0, 16'h00A0});
    exp_q.push_back({1'b0, 16'h00B0});
    exp_q.push_back({1'b1, 16'h4400});  // PLAIN, sub 1
    send_event(16'h00A0, 16'h00B0, DII_TYPE_PLAIN, 4'h1, 0, '0, 0);
    exp_q.push_back({1'b0, 16'h00C0});
    exp_q.push_back({1'b0, 16'h00D0});
    exp_q.push_back({1'b1, 16'h0800});  // REG, sub 2
    send_event(16'h00C0, 16'h00D0, DII_TYPE_REG, 4'h2, 0, '0, 0);
    wait_drain("t2_drain");
    check("t2_nflits", 32'(fire_cyc.size()), 32'd6);
    if (fire_cyc.size() == 6)
      check("t2_idle_gap", 32'(fire_cyc[3] - fire_cyc[2]), 32'd2);
    check("t2_consumed", 32'(consumed - c0), 32'd2);

    // 3: same as 1 with ready toggling 1,0,0,1,0,1,...
    fire_cyc.delete();
    c0 = consumed;
    pidx = 0;
    ready_mode = 1;
    exp_q.push_back({1'b0, 16'h0001});
    exp_q.push_back({1'b0, 16'h0005});
    exp_q.push_back({1'b0, 16'h8C00});
    exp_q.push_back({1'b0, 16'hCAFE});
    exp_q.push_back({1'b1, 16'hBEEF});
    vec = '0; vec[31:0] = {16'hBEEF, 16'hCAFE};
    send_event(16'h0001, 16'h0005, DII_TYPE_EVENT, 4'h3, 2, vec, 0);
    wait_drain("t3_drain");
    ready_mode = 0;
    check("t3_nflits", 32'(fire_cyc.size()), 32'd5);
    check("t3_consumed", 32'(consumed - c0), 32'd1);

    // 4: over-long count is clamped to MAX words
    fire_cyc.delete();
    for (int i = 0; i < MAX; i++) vec[16*i +: 16] = 16'h1000 + 16'(i);
    send_event(16'h0123, 16'h0456, DII_TYPE_EVENT, 4'h7, MAX + 3, vec, 1);
    wait_drain("t4_drain");
    check("t4_nflits", 32'(fire_cyc.size()), 32'(DII_HDR_FLITS + MAX));

    // 5: inputs changed right after accept do not leak into the packet
    for (int i = 0; i < MAX; i++) vec[16*i +: 16] = 16'h5A00 + 16'(i);
    send_event(16'h0042, 16'h0024, DII_TYPE_EVENT, 4'h9, 3, vec, 1);
    dest = 16'hFFFF; id = 16'hEEEE; event_data = '1;
    dii_type = 2'b11; type_sub = 4'hF; data_num_words = CNT_W'(1);
    wait_drain("t5_drain");

    // 6: reset mid-payload aborts the packet; a fresh packet follows
    base = fires;
    for (int i = 0; i < MAX; i++) vec[16*i +: 16] = 16'h7700 + 16'(i);
    send_event(16'h0E00, 16'h0F00, DII_TYPE_EVENT, 4'h4, 4, vec, 1);
    for (int c = 0; c < 50 && fires < base + 4; c++) @(posedge clk);
    check("t6_reached_payload", 32'(fires >= base + 4), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_abort_valid", 32'(link.flit.valid), 32'd0);
    check("t6_abort_last", 32'(link.flit.last), 32'd0);
    check("t6_abort_state", 32'(state_dbg), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_post_state", 32'(state_dbg), 32'd0);
    check("t6_post_valid", 32'(link.flit.valid), 32'd0);
    for (int i = 0; i < MAX; i++) vec[16*i +: 16] = 16'h3300 + 16'(i);
    send_event(16'h0AAA, 16'h0BBB, DII_TYPE_EVENT, 4'h5, 2, vec, 1);
    wait_drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
